// File: rtl/nco_pkg.sv
// Shared definitions for the NCO controller: sample width, FSM state
// encoding, quadrant codes and the saturating two's-complement negate.
package nco_pkg;

  // Default angle/sample width shared with the sine stage.
  localparam int NCO_W = 20;

  // Controller states: wait for run, pulse start, wait for done, hold result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } nco_state_t;

  // Quadrant codes taken from the top two phase bits.
  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;

  // Negate the low w bits of x as a signed w-bit value. The most negative
  // value has no positive counterpart, so it saturates to the largest
  // positive value instead of wrapping back onto itself. The result is
  // returned in the low w bits; callers truncate with a size cast.
  function automatic logic [31:0] sat_neg(input logic [31:0] x, input int w);
    logic [31:0] mask;
    logic [31:0] min_val;
    logic [31:0] max_val;
    mask    = (32'd1 << w) - 32'd1;
    min_val = 32'd1 << (w - 1);
    max_val = min_val - 32'd1;
    if ((x & mask) == min_val) begin
      return max_val;
    end
    return (~x + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/nco_ctrl_quad_fix.sv
// quad_fix: maps first-quadrant sine/cosine results back to the full circle
// using the quadrant of the sample's phase. Purely combinational.
module quad_fix
  import nco_pkg::*;
#(
  parameter int W = NCO_W
) (
  input  logic [1:0]   q,
  input  logic [W-1:0] sin_z0,
  input  logic [W-1:0] cos_z0,
  output logic [W-1:0] sin_fix,
  output logic [W-1:0] cos_fix
);

  logic [W-1:0] sin_neg;
  logic [W-1:0] cos_neg;

  assign sin_neg = W'(sat_neg(32'(sin_z0), W));
  assign cos_neg = W'(sat_neg(32'(cos_z0), W));

  // Rotate the first-quadrant pair by q * 90 degrees.
  always_comb begin
    sin_fix = sin_z0;
    cos_fix = cos_z0;
    case (q)
      QUAD_0: begin
        sin_fix = sin_z0;
        cos_fix = cos_z0;
      end
      QUAD_1: begin
        sin_fix = cos_z0;
        cos_fix = sin_neg;
      end
      QUAD_2: begin
        sin_fix = sin_neg;
        cos_fix = cos_neg;
      end
      QUAD_3: begin
        sin_fix = cos_neg;
        cos_fix = sin_z0;
      end
      default: begin
        sin_fix = sin_z0;
        cos_fix = cos_z0;
      end
    endcase
  end

endmodule

// File: rtl/nco_ctrl.sv
// nco_ctrl: phase accumulator and request/response sequencer for an
// external first-quadrant sine stage, with quadrant correction of the
// returned samples and a valid/ready output handshake.
// Optional build macro NCO_CTRL_TIMEOUT_EN adds a WAIT-state watchdog that
// sets a sticky err flag and abandons the sample when done never arrives;
// without it, WAIT waits indefinitely and err is tied low.
module nco_ctrl
  import nco_pkg::*;
#(
  parameter int W       = NCO_W,
  parameter int TIMEOUT = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         run,
  input  logic [W-1:0] freq_word,
  output logic [W-1:0] z0,
  output logic         start,
  input  logic         done,
  input  logic [W-1:0] cos_z0,
  input  logic [W-1:0] sin_z0,
  output logic [W-1:0] cos_out,
  output logic [W-1:0] sin_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         err
);

  nco_state_t   state;
  nco_state_t   next_state;
  logic [W-1:0] phase;
  logic [1:0]   q;
  logic [W-1:0] sin_fix;
  logic [W-1:0] cos_fix;
  logic         timeout_hit;

  // The quadrant of the sample in flight; phase only moves when done is
  // accepted, so q stays tied to the angle that was issued.
  assign q = phase[W-1:W-2];

  quad_fix #(
    .W(W)
  ) u_quad_fix (
    .q      (q),
    .sin_z0 (sin_z0),
    .cos_z0 (cos_z0),
    .sin_fix(sin_fix),
    .cos_fix(cos_fix)
  );

  assign start     = (state == ISSUE);
  assign out_valid = (state == HOLD);

`ifdef NCO_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;
  logic          err_q;

  // wait_cnt holds the number of cycles since start while in WAIT, so the
  // watchdog fires on the cycle that makes err visible TIMEOUT cycles after
  // start. A done arriving in that same cycle still wins.
  assign timeout_hit = (state == WAIT) && !done && (wait_cnt == CW'(TIMEOUT - 1));
  assign err         = err_q;

  // Watchdog counter and sticky error flag, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        wait_cnt <= CW'(1);
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // Next-state logic; once issued, a sample always completes regardless of run.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (run) begin
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        next_state = WAIT;
      end
      WAIT: begin
        if (done) begin
          next_state = HOLD;
        end else if (timeout_hit) begin
          next_state = IDLE;
        end
      end
      HOLD: begin
        if (out_ready) begin
          next_state = run ? ISSUE : IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Angle launch, result capture and phase advance. z0 is loaded on entry to
  // ISSUE so it is stable while start is high and until the next issue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase   <= '0;
      z0      <= '0;
      cos_out <= '0;
      sin_out <= '0;
    end else begin
      if (next_state == ISSUE) begin
        z0 <= {2'b00, phase[W-3:0]};
      end
      if ((state == WAIT) && done) begin
        phase   <= phase + freq_word;
        cos_out <= cos_fix;
        sin_out <= sin_fix;
      end
    end
  end

endmodule

// File: tb/tb_nco_ctrl.sv
// tb_nco_ctrl: directed self-checking bench for nco_ctrl with a behavioural
// sine stage that answers each start after a programmable latency.
module tb_nco_ctrl;

  logic        clock;
  logic        reset;
  logic        run;
  logic [19:0] freq_word;
  logic [19:0] z0;
  logic        start;
  logic        done;
  logic [19:0] cos_z0;
  logic [19:0] sin_z0;
  logic [19:0] cos_out;
  logic [19:0] sin_out;
  logic        out_valid;
  logic        out_ready;
  logic        err;

  logic        modelDone;
  logic        spuriousDone;
  logic [19:0] sinIn;
  logic [19:0] cosIn;
  logic [19:0] capZ0;
  logic [19:0] modelS;
  logic [19:0] modelC;
  bit          modelEnable;
  bit          forceVals;
  int          modelLat;

  int testsRun;
  int testsFailed;

  assign done   = modelDone | spuriousDone;
  assign sin_z0 = sinIn;
  assign cos_z0 = cosIn;

  nco_ctrl #(
    .W      (20),
    .TIMEOUT(64)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .run      (run),
    .freq_word(freq_word),
    .z0       (z0),
    .start    (start),
    .done     (done),
    .cos_z0   (cos_z0),
    .sin_z0   (sin_z0),
    .cos_out  (cos_out),
    .sin_out  (sin_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err      (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural sine stage: returns s = z0 + 1, c = z0 + 0x100 (or forced
  // values) with done high modelLat cycles after the start cycle.
  always begin
    @(negedge clock);
    if (modelEnable && start === 1'b1) begin
      capZ0 = z0;
      repeat (modelLat) @(negedge clock);
      modelDone = 1'b1;
      sinIn     = forceVals ? modelS : capZ0 + 20'h00001;
      cosIn     = forceVals ? modelC : capZ0 + 20'h00100;
      @(negedge clock);
      modelDone = 1'b0;
    end
  end

  // Overall time bound so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: got time %0t, required completion earlier", $time);
    $fatal(1, "[TB] simulation time bound exceeded");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic runVal, input logic [19:0] freqVal, input logic readyVal);
    run       = runVal;
    freq_word = freqVal;
    out_ready = readyVal;
  endtask

  task automatic pulseReset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic waitStart(input string tag);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (start !== 1'b1 && n < 100);
    checkOutput({tag, "_start"}, 32'(start), 32'd1);
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (out_valid !== 1'b1 && n < 100);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic doSample(input string tag, input logic [19:0] expZ0, input logic [19:0] expSin,
                          input logic [19:0] expCos, input bit dropRun);
    waitStart(tag);
    checkOutput({tag, "_z0"}, 32'(z0), 32'(expZ0));
    waitValid(tag);
    checkOutput({tag, "_sin"}, 32'(sin_out), 32'(expSin));
    checkOutput({tag, "_cos"}, 32'(cos_out), 32'(expCos));
    if (dropRun) run = 1'b0;
  endtask

  initial begin
    testsRun     = 0;
    testsFailed  = 0;
    modelDone    = 1'b0;
    spuriousDone = 1'b0;
    sinIn        = '0;
    cosIn        = '0;
    capZ0        = '0;
    modelS       = '0;
    modelC       = '0;
    modelEnable  = 1'b1;
    forceVals    = 1'b0;
    modelLat     = 2;
    reset        = 1'b0;
    applyStimulus(1'b0, 20'h00000, 1'b1);

    // Reset values
    repeat (2) @(negedge clock);
    checkOutput("rst_z0", 32'(z0), 32'd0);
    checkOutput("rst_start", 32'(start), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_cos", 32'(cos_out), 32'd0);
    checkOutput("rst_sin", 32'(sin_out), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    reset = 1'b1;

    // Phase sweep across the q=0 -> q=1 boundary
    applyStimulus(1'b1, 20'h10000, 1'b1);
    doSample("sweep0", 20'h00000, 20'h00001, 20'h00100, 1'b0);
    doSample("sweep1", 20'h10000, 20'h10001, 20'h10100, 1'b0);
    doSample("sweep2", 20'h20000, 20'h20001, 20'h20100, 1'b0);
    doSample("sweep3", 20'h30000, 20'h30001, 20'h30100, 1'b0);
    doSample("sweep4", 20'h00000, 20'h00100, 20'hFFFFF, 1'b1);
    repeat (3) @(negedge clock);

    // Quadrant 2 correction and saturating negation
    pulseReset();
    forceVals = 1'b1;
    modelS    = 20'h12345;
    modelC    = 20'h0ABCD;
    applyStimulus(1'b1, 20'h80100, 1'b1);
    doSample("q2a", 20'h00000, 20'h12345, 20'h0ABCD, 1'b0);
    doSample("q2b", 20'h00100, 20'hEDCBB, 20'hF5433, 1'b1);
    repeat (3) @(negedge clock);
    pulseReset();
    modelC = 20'h80000;
    applyStimulus(1'b1, 20'h80100, 1'b1);
    doSample("satA", 20'h00000, 20'h12345, 20'h80000, 1'b0);
    doSample("satB", 20'h00100, 20'hEDCBB, 20'h7FFFF, 1'b1);
    forceVals = 1'b0;
    repeat (3) @(negedge clock);

    // Back-pressure: out_ready low for 10 cycles in HOLD
    pulseReset();
    applyStimulus(1'b1, 20'h01000, 1'b0);
    doSample("hold", 20'h00000, 20'h00001, 20'h00100, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_start", 32'(start), 32'd0);
      checkOutput("hold_sin", 32'(sin_out), 32'h00001);
      checkOutput("hold_cos", 32'(cos_out), 32'h00100);
    end
    applyStimulus(1'b0, 20'h01000, 1'b1);
    @(negedge clock);
    checkOutput("hold_drop", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 20'h01000, 1'b1);
    doSample("holdNext", 20'h01000, 20'h01001, 20'h01100, 1'b1);
    repeat (3) @(negedge clock);

    // run dropped the cycle after start; spurious done in IDLE
    pulseReset();
    applyStimulus(1'b1, 20'h02000, 1'b1);
    waitStart("drop");
    checkOutput("drop_z0", 32'(z0), 32'h00000);
    @(negedge clock);
    run = 1'b0;
    waitValid("drop");
    checkOutput("drop_sin", 32'(sin_out), 32'h00001);
    checkOutput("drop_cos", 32'(cos_out), 32'h00100);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      checkOutput("drop_idleValid", 32'(out_valid), 32'd0);
      checkOutput("drop_idleStart", 32'(start), 32'd0);
    end
    spuriousDone = 1'b1;
    @(negedge clock);
    spuriousDone = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checkOutput("spurious_valid", 32'(out_valid), 32'd0);
    end
    applyStimulus(1'b1, 20'h02000, 1'b1);
    doSample("dropNext", 20'h02000, 20'h02001, 20'h02100, 1'b1);
    repeat (3) @(negedge clock);

    // Asynchronous reset in WAIT, then a late done after release
    pulseReset();
    applyStimulus(1'b1, 20'h03000, 1'b1);
    doSample("rstPre", 20'h00000, 20'h00001, 20'h00100, 1'b0);
    modelLat = 6;
    waitStart("rstMid");
    checkOutput("rstMid_z0", 32'(z0), 32'h03000);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    run   = 1'b0;
    #1;
    checkOutput("rstMid_z0zero", 32'(z0), 32'd0);
    checkOutput("rstMid_start", 32'(start), 32'd0);
    checkOutput("rstMid_valid", 32'(out_valid), 32'd0);
    checkOutput("rstMid_cos", 32'(cos_out), 32'd0);
    checkOutput("rstMid_sin", 32'(sin_out), 32'd0);
    checkOutput("rstMid_err", 32'(err), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      checkOutput("lateDone_valid", 32'(out_valid), 32'd0);
      checkOutput("lateDone_start", 32'(start), 32'd0);
    end
    modelLat = 2;
    applyStimulus(1'b1, 20'h03000, 1'b1);
    doSample("rstFirst", 20'h00000, 20'h00001, 20'h00100, 1'b1);
    repeat (3) @(negedge clock);

`ifdef NCO_CTRL_TIMEOUT_EN
    // Watchdog: no done ever arrives
    pulseReset();
    modelEnable = 1'b0;
    applyStimulus(1'b1, 20'h04000, 1'b1);
    waitStart("tmo");
    run = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clock);
      if (k == 63) checkOutput("tmo_errEarly", 32'(err), 32'd0);
      if (k == 64) checkOutput("tmo_errSet", 32'(err), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("tmo_idleStart", 32'(start), 32'd0);
      checkOutput("tmo_idleValid", 32'(out_valid), 32'd0);
    end
    modelEnable = 1'b1;
    applyStimulus(1'b1, 20'h04000, 1'b1);
    doSample("tmoNext", 20'h00000, 20'h00001, 20'h00100, 1'b1);
    checkOutput("tmo_errSticky", 32'(err), 32'd1);
    repeat (3) @(negedge clock);
`else
    // Without the watchdog, WAIT persists and err stays low
    pulseReset();
    modelEnable = 1'b0;
    applyStimulus(1'b1, 20'h04000, 1'b1);
    waitStart("noTmo");
    run = 1'b0;
    repeat (80) @(negedge clock);
    checkOutput("noTmo_err", 32'(err), 32'd0);
    checkOutput("noTmo_start", 32'(start), 32'd0);
    checkOutput("noTmo_valid", 32'(out_valid), 32'd0);
    modelEnable = 1'b1;
    pulseReset();
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/nco_ctrl.md
NCO_CTRL -- requirements
Module: nco_ctrl

Interface
REQ-001 SHALL provide parameter W, default 20, meaning the angle and sample width shared with the sine stage.
REQ-002 SHALL provide parameter TIMEOUT, default 64, meaning the maximum number of cycles to wait for done after start.
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 run  input  1  level; while high, samples are generated continuously.
REQ-006 freq_word  input  W  phase increment per sample, in binary-angle units (2^W = 2*pi).
REQ-007 z0  output  W  first-quadrant angle to the sine stage.
REQ-008 start  output  1  one-cycle request pulse to the sine stage.
REQ-009 done  input  1  sine-stage completion pulse.
REQ-010 cos_z0, sin_z0  input  W each  signed sine-stage results, valid in the cycle done is high.
REQ-011 cos_out, sin_out  output  W each  signed, quadrant-corrected sample.
REQ-012 out_valid  output  1 and out_ready input 1  output handshake.
REQ-013 err  output  1  sticky timeout flag.

Function
REQ-014 Phase accumulator: W bits, unsigned, wraps modulo 2^W; q = phase[W-1:W-2] and r = phase[W-3:0].
REQ-015 z0 SHALL equal {2'b00, r}, so 2^(W-2) = pi/2 in the sine-stage encoding.
REQ-016 FSM states: IDLE, ISSUE, WAIT, HOLD.
REQ-017 IDLE goes to ISSUE when run=1 and stays in IDLE otherwise.
REQ-018 ISSUE drives start=1 for exactly one cycle with z0 stable, then goes to WAIT; z0 holds until the next ISSUE.
REQ-019 WAIT, on done=1: capture the corrected results, set phase += freq_word (freq_word sampled in this cycle), then go to HOLD.
REQ-020 Correction by q, using s = sin_z0 and c = cos_z0:
- q=0: sin=s, cos=c.
- q=1: sin=c, cos=-s.
- q=2: sin=-s, cos=-c.
- q=3: sin=-c, cos=s.
REQ-021 Negation SHALL be two's complement, saturating -(-2^(W-1)) to 2^(W-1)-1.
REQ-022 HOLD holds out_valid=1 with cos_out and sin_out stable until out_ready=1; the transfer completes on the cycle where out_valid and out_ready are both high.
REQ-023 After the transfer, the FSM goes to ISSUE if run=1, else to IDLE; out_valid drops the cycle after the transfer.
REQ-024 Deasserting run in ISSUE, WAIT or HOLD SHALL NOT abort the sample; it completes and the FSM then goes to IDLE.
REQ-025 done received outside WAIT SHALL be ignored.
REQ-026 Minimum latency: start to out_valid = sine-stage latency + 1 cycle.
REQ-027 freq_word=0 SHALL repeat the same phase; wrap past 2^W-1 SHALL be seamless.

Reset
REQ-028 reset=0 SHALL asynchronously force: FSM to IDLE, phase=0, z0=0, start=0, cos_out=0, sin_out=0, out_valid=0, err=0.
REQ-029 Reset mid-operation SHALL discard any in-flight sample, and a late done after reset release SHALL be ignored.

Configuration
REQ-030 With NCO_CTRL_TIMEOUT_EN defined: a counter runs in WAIT; if it reaches TIMEOUT cycles without done, err is set, phase is not advanced, and the FSM goes to IDLE.
REQ-031 err SHALL clear only on reset.
REQ-032 Without NCO_CTRL_TIMEOUT_EN: no counter is built, WAIT waits indefinitely, and err is tied to 0.

Structure
REQ-033 Shared package nco_pkg SHALL hold the FSM state encoding, the quadrant constants, W, and the saturating-negate function.
REQ-034 One sub-module, quad_fix, SHALL perform the combinational quadrant correction of REQ-020/021.
REQ-035 The FSM, accumulator and watchdog SHALL stay in nco_ctrl.

Verification
REQ-036 Reset low mid-WAIT -> all outputs 0 immediately; with run=1 after release, the first z0 is 0.
REQ-037 freq_word=0x10000, run=1, out_ready=1 -> successive z0 values 0x00000, 0x10000, 0x20000, 0x30000, 0x00000 (the q=1 sample at phase 0x40000 gives z0=0x00000); q progresses 0,0,0,0,1,...
REQ-038 Model stage returning s=0x12345 and c=0x0ABCD at phase 0x80100 (q=2) -> sin_out=0xEDCBB, cos_out=0xF5433; with c=0x80000 at q=2 -> cos_out=0x7FFFF.
REQ-039 out_ready held low for 10 cycles in HOLD -> out_valid is held, data stays stable, no new start is issued, and phase advances by only one freq_word.
REQ-040 run dropped one cycle after start -> exactly one sample is delivered, then IDLE; spurious done pulses while in IDLE produce no out_valid.
REQ-041 NCO_CTRL_TIMEOUT_EN defined and done never asserted -> err=1 exactly 64 cycles after start, FSM in IDLE, phase unchanged.
